mips_commit_checker: RTL

- Hardware-side counterpart to the MIPS core's clock/stimulus driver.
- Sits beside mips_core and observes register-file writeback events.
- Compares each event in order against a preloaded expected trace.
- Reports pass, fail or timeout, plus counters and first-error details, so a bench or FPGA wrapper only toggles clock and reads the verdict.

---
 rtl/mips_commit_checker.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mips_commit_checker.sv
// mips_commit_checker
//
// Checks register-file writebacks from mips_core against a preloaded expected trace. A bench or
// FPGA wrapper preloads the trace, pulses start, toggles the clock and reads back a registered
// verdict (pass / fail / timeout) together with counters and the details of the first mismatch.
//
// Build option:
//   MIPS_CHK_CONTINUE_EN - when defined, a mismatch does not stop checking. The trace is walked
//                          to the end, errors are accumulated, and the verdict is decided when
//                          the last entry has been consumed. The default build stops at the
//                          first mismatch.
//
// Ports:
//   clock        core clock, rising edge
//   reset        synchronous, active-high; the expected-trace memory is not cleared
//   load_we      write {load_reg, load_val} into entry load_addr (honoured only in IDLE)
//   load_addr    expected-entry index
//   load_reg     expected destination register
//   load_val     expected write data
//   exp_count    number of valid expected entries, sampled on start and clamped to DEPTH
//   start        begin checking (accepted in IDLE and in any terminal state)
//   wb_valid     core performs a register write this cycle
//   wb_reg       writeback destination register
//   wb_data      writeback data
//   busy         checking is in progress
//   done         a verdict has been reached
//   pass         the trace matched completely
//   fail         mismatch or timeout
//   timeout      the failure was caused by the timeout
//   match_count  entries matched so far
//   error_count  mismatches counted
//   err_index    trace index of the first mismatch
//   err_data     wb_data of the first mismatch
//   cycle_count  cycles spent checking, saturating at TIMEOUT

module mips_commit_checker #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned DEPTH_W = 5,
  parameter int unsigned CYC_W   = 16,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_we,
  input  logic [DEPTH_W-1:0] load_addr,
  input  logic [4:0]         load_reg,
  input  logic [31:0]        load_val,
  input  logic [DEPTH_W:0]   exp_count,
  input  logic               start,
  input  logic               wb_valid,
  input  logic [4:0]         wb_reg,
  input  logic [31:0]        wb_data,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic [DEPTH_W:0]   match_count,
  output logic [DEPTH_W:0]   error_count,
  output logic [DEPTH_W-1:0] err_index,
  output logic [31:0]        err_data,
  output logic [CYC_W-1:0]   cycle_count
);

  localparam int unsigned CntW = DEPTH_W + 1;

  localparam logic [CntW-1:0]  DepthC     = CntW'(DEPTH);
  localparam logic [CYC_W-1:0] TimeoutC   = CYC_W'(TIMEOUT);
  localparam logic [CYC_W-1:0] TimeoutM1C = CYC_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StPass,
    StFail,
    StTout
  } state_e;

  state_e state_q, state_d;

  // Trace progress: idx_q is the next entry to compare, limit_q the clamped trace length.
  logic [CntW-1:0] idx_q, idx_d;
  logic [CntW-1:0] limit_q, limit_d;

  // Next values of the registered outputs.
  logic [CntW-1:0]    match_d;
  logic [CntW-1:0]    err_cnt_d;
  logic [DEPTH_W-1:0] err_index_d;
  logic [31:0]        err_data_d;
  logic [CYC_W-1:0]   cycle_d;

  // Expected trace: {reg, data} per entry. No reset so a trace survives an aborted run.
  logic [36:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (load_we && (state_q == StIdle)) begin
      mem[load_addr] <= {load_reg, load_val};
    end
  end

  logic [4:0]      exp_reg;
  logic [31:0]     exp_val;
  logic            event_seen;
  logic            event_match;
  logic [CntW-1:0] start_limit;

  // idx_q stays below limit_q (<= DEPTH) while running, so the low bits always address
  // a valid entry.
  assign {exp_reg, exp_val} = mem[idx_q[DEPTH_W-1:0]];

  // Writes to $zero never reach the register file, so they are not trace events.
  assign event_seen  = wb_valid && (wb_reg != 5'd0);
  assign event_match = (wb_reg == exp_reg) && (wb_data == exp_val);

  assign start_limit = (exp_count > DepthC) ? DepthC : exp_count;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    limit_d     = limit_q;
    match_d     = match_count;
    err_cnt_d   = error_count;
    err_index_d = err_index;
    err_data_d  = err_data;
    cycle_d     = cycle_count;

    unique case (state_q)
      StIdle, StPass, StFail, StTout: begin
        // A terminal state re-arms exactly like IDLE; the trace memory is kept.
        if (start) begin
          limit_d     = start_limit;
          idx_d       = '0;
          match_d     = '0;
          err_cnt_d   = '0;
          err_index_d = '0;
          err_data_d  = '0;
          cycle_d     = '0;
          state_d     = (start_limit == '0) ? StPass : StRun;
        end
      end

      StRun: begin
        if (cycle_count != TimeoutC) begin
          cycle_d = cycle_count + CYC_W'(1);
        end

        if (event_seen) begin
          if (event_match) begin
            idx_d   = idx_q + CntW'(1);
            match_d = match_count + CntW'(1);
            if (idx_d == limit_q) begin
              // Only reachable with errors when mismatches do not stop the run.
              state_d = (error_count == '0) ? StPass : StFail;
            end
          end else begin
            err_cnt_d = error_count + CntW'(1);
            if (error_count == '0) begin
              err_index_d = idx_q[DEPTH_W-1:0];
              err_data_d  = wb_data;
            end
`ifdef MIPS_CHK_CONTINUE_EN
            idx_d = idx_q + CntW'(1);
            if (idx_d == limit_q) begin
              state_d = StFail;
            end
`else
            state_d = StFail;
`endif
          end
        end

        // The event is judged first; the timeout only applies if it produced no verdict.
        if ((state_d == StRun) && (cycle_count == TimeoutM1C)) begin
          state_d = StTout;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      limit_q     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      match_count <= '0;
      error_count <= '0;
      err_index   <= '0;
      err_data    <= '0;
      cycle_count <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      limit_q     <= limit_d;
      busy        <= (state_d == StRun);
      done        <= (state_d == StPass) || (state_d == StFail) || (state_d == StTout);
      pass        <= (state_d == StPass);
      fail        <= (state_d == StFail) || (state_d == StTout);
      timeout     <= (state_d == StTout);
      match_count <= match_d;
      error_count <= err_cnt_d;
      err_index   <= err_index_d;
      err_data    <= err_data_d;
      cycle_count <= cycle_d;
    end
  end

endmodule
